mem_access_ctrl: RTL and testbench

- Sequential load/store sequencer between the core's execute stage and the `mem` block.
- Accepts one load/store request per transaction over a valid/ready handshake.
- Performs byte-lane alignment, write-mask generation and load extraction/extension, then drives `mem`'s enable/cmd/valid protocol.
- Checks alignment and watches for memory timeout, then returns a single response to the writeback stage.

---
 rtl/mem_access_ctrl_pkg.sv | 26 ++
 rtl/lsu_lane_align.sv | 79 +++++++
 rtl/mem_access_ctrl.sv | 152 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the load/store sequencer.
// Holds memory command codes, RV32I load/store width codes, response
// error codes and the sequencer state encoding.
package mem_access_ctrl_pkg;

  localparam logic MEM_CMD_READ  = 1'b0;
  localparam logic MEM_CMD_WRITE = 1'b1;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_ILLEGAL  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic for the load/store sequencer.
// Ports:
//   cmd        - 0 load, 1 store
//   funct3     - RV32I width/sign code
//   offset     - byte offset within the word (addr[1:0])
//   wdata      - right-justified store data
//   load_word  - raw word returned by memory
//   illegal    - funct3 not valid for cmd
//   misaligned - halfword/word access not naturally aligned
//   mask       - byte write mask (0 for loads)
//   write_data - store data shifted into its lanes, unused lanes 0
//   load_data  - extracted and extended load result
module lsu_lane_align (
  input  logic        cmd,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] load_word,
  output logic        illegal,
  output logic        misaligned,
  output logic [3:0]  mask,
  output logic [31:0] write_data,
  output logic [31:0] load_data
);
  import mem_access_ctrl_pkg::*;

  logic [4:0]  bit_shift;
  logic [31:0] lane_word;

  assign bit_shift = {offset, 3'b000};
  // Bring the addressed byte/halfword down to bit 0 for extraction.
  assign lane_word = load_word >> bit_shift;

  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    mask       = '0;
    write_data = '0;
    load_data  = '0;
    if (cmd == MEM_CMD_WRITE) begin
      case (funct3)
        F3_B: begin
          mask       = 4'b0001 << offset;
          write_data = {24'b0, wdata[7:0]} << bit_shift;
        end
        F3_H: begin
          misaligned = offset[0];
          mask       = 4'b0011 << offset;
          write_data = {16'b0, wdata[15:0]} << bit_shift;
        end
        F3_W: begin
          misaligned = |offset;
          mask       = 4'b1111;
          write_data = wdata;
        end
        default: illegal = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_B:  load_data = {{24{lane_word[7]}}, lane_word[7:0]};
        F3_BU: load_data = {24'b0, lane_word[7:0]};
        F3_H: begin
          misaligned = offset[0];
          load_data  = {{16{lane_word[15]}}, lane_word[15:0]};
        end
        F3_HU: begin
          misaligned = offset[0];
          load_data  = {16'b0, lane_word[15:0]};
        end
        F3_W: begin
          misaligned = |offset;
          load_data  = load_word;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between execute stage and the mem block.
// Accepts one request (req_*), checks legality/alignment, drives the mem
// enable/cmd/valid protocol with a timeout, and returns one response (resp_*).
// Ports:
//   clk, reset_n            - clock, async active-low reset
//   req_valid/req_ready     - request handshake; req_cmd/funct3/addr/wdata/rd payload
//   resp_valid/resp_ready   - response handshake; resp_rdata/rd/err payload
//   mem_addr/mask/enable/cmd/write_data - registered access to mem
//   mem_load_data/mem_valid - mem completion and read data
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TIMEOUT_W      = 7
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_cmd,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic [1:0]  resp_err,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_mask,
  output logic        mem_enable,
  output logic        mem_cmd,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_load_data,
  input  logic        mem_valid
);
  import mem_access_ctrl_pkg::*;

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  state_t               state;
  logic                 cmd_q;
  logic [2:0]           funct3_q;
  logic [1:0]           offset_q;
  logic [TIMEOUT_W-1:0] timeout_cnt;

  logic        is_idle;
  logic        al_cmd;
  logic [2:0]  al_funct3;
  logic [1:0]  al_offset;
  logic        al_illegal;
  logic        al_misaligned;
  logic [3:0]  al_mask;
  logic [31:0] al_write_data;
  logic [31:0] al_load_data;

  assign is_idle   = (state == ST_IDLE);
  assign req_ready = reset_n && is_idle;

  // One lane aligner serves both phases: it decodes the incoming request
  // while idle and extracts load data from the latched request afterwards.
  assign al_cmd    = is_idle ? req_cmd          : cmd_q;
  assign al_funct3 = is_idle ? req_funct3       : funct3_q;
  assign al_offset = is_idle ? req_addr[1:0]    : offset_q;

  lsu_lane_align u_lane_align (
    .cmd        (al_cmd),
    .funct3     (al_funct3),
    .offset     (al_offset),
    .wdata      (req_wdata),
    .load_word  (mem_load_data),
    .illegal    (al_illegal),
    .misaligned (al_misaligned),
    .mask       (al_mask),
    .write_data (al_write_data),
    .load_data  (al_load_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      cmd_q          <= 1'b0;
      funct3_q       <= '0;
      offset_q       <= '0;
      timeout_cnt    <= '0;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      resp_rd        <= '0;
      resp_err       <= ERR_NONE;
      mem_addr       <= '0;
      mem_mask       <= '0;
      mem_enable     <= 1'b0;
      mem_cmd        <= 1'b0;
      mem_write_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            cmd_q       <= req_cmd;
            funct3_q    <= req_funct3;
            offset_q    <= req_addr[1:0];
            resp_rd     <= req_rd;
            resp_rdata  <= '0;
            timeout_cnt <= '0;
            if (al_illegal) begin
              resp_err   <= ERR_ILLEGAL;
              resp_valid <= 1'b1;
              state      <= ST_RESP;
            end else if (al_misaligned) begin
              resp_err   <= ERR_MISALIGN;
              resp_valid <= 1'b1;
              state      <= ST_RESP;
            end else begin
              resp_err       <= ERR_NONE;
              mem_addr       <= {req_addr[31:2], 2'b00};
              mem_mask       <= al_mask;
              mem_cmd        <= req_cmd;
              mem_write_data <= al_write_data;
              mem_enable     <= 1'b1;
              state          <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          // Completion is checked first so a late mem_valid on the final
          // timeout cycle still counts as success.
          if (mem_valid) begin
            mem_enable <= 1'b0;
            resp_rdata <= (cmd_q == MEM_CMD_READ) ? al_load_data : '0;
            resp_err   <= ERR_NONE;
            resp_valid <= 1'b1;
            state      <= ST_RESP;
          end else if (timeout_cnt == TIMEOUT_LAST) begin
            mem_enable <= 1'b0;
            resp_err   <= ERR_TIMEOUT;
            resp_valid <= 1'b1;
            state      <= ST_RESP;
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_cmd;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic [1:0]  resp_err;
  logic [31:0] mem_addr;
  logic [3:0]  mem_mask;
  logic        mem_enable, mem_cmd;
  logic [31:0] mem_write_data, mem_load_data;
  logic        mem_valid;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT_CYCLES(64), .TIMEOUT_W(7)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_rd(resp_rd), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_mask(mem_mask), .mem_enable(mem_enable), .mem_cmd(mem_cmd),
    .mem_write_data(mem_write_data), .mem_load_data(mem_load_data), .mem_valid(mem_valid)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: rules written as plain arithmetic on sizes and offsets.
  function automatic int acc_size(input logic [2:0] f3);
    if (f3 == 3'd2) return 4;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 1;
  endfunction

  function automatic logic [1:0] model_err(input logic cmd, input logic [2:0] f3,
                                           input logic [31:0] addr);
    bit legal;
    int a;
    if (cmd == 1'b0) legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    else             legal = (f3 <= 2);
    if (!legal) return 2'd3;
    a = int'(addr[1:0]);
    if (a % acc_size(f3) != 0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [31:0] model_mask(input logic cmd, input logic [2:0] f3,
                                             input logic [31:0] addr);
    int off;
    off = int'(addr[1:0]);
    if (cmd == 1'b0) return 32'd0;
    if (acc_size(f3) == 4) return 32'hF;
    if (acc_size(f3) == 2) return 32'(3 << off);
    return 32'(1 << off);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] wd);
    int off;
    off = int'(addr[1:0]);
    if (acc_size(f3) == 4) return wd;
    if (acc_size(f3) == 2) return (wd & 32'hFFFF) << (8 * off);
    return (wd & 32'hFF) << (8 * off);
  endfunction

  function automatic logic [31:0] model_rdata(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] word);
    logic [31:0] seg, v;
    seg = word >> (8 * int'(addr[1:0]));
    case (f3)
      3'd0: begin v = seg & 32'hFF;   if (v >= 32'd128)   v = v + 32'hFFFFFF00; end
      3'd4: v = seg & 32'hFF;
      3'd1: begin v = seg & 32'hFFFF; if (v >= 32'd32768) v = v + 32'hFFFF0000; end
      3'd5: v = seg & 32'hFFFF;
      default: v = word;
    endcase
    return v;
  endfunction

  // delay < 0 means mem never answers.
  task automatic run_txn(input logic cmd, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd, input int delay,
                         input logic [31:0] ldata, input int hold);
    logic [1:0]  e;
    logic [31:0] exp_rdata;
    int n;
    e = model_err(cmd, f3, addr);
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    check_val("req_ready_before", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_cmd = cmd; req_funct3 = f3; req_addr = addr;
    req_wdata = wd; req_rd = rd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    if (e != 2'd0) begin
      check_val("err_no_enable", 32'(mem_enable), 32'd0);
      check_val("err_resp_valid", 32'(resp_valid), 32'd1);
    end else begin
      check_val("mem_enable", 32'(mem_enable), 32'd1);
      check_val("mem_addr", mem_addr, addr & 32'hFFFFFFFC);
      check_val("mem_mask", 32'(mem_mask), model_mask(cmd, f3, addr));
      check_val("mem_cmd", 32'(mem_cmd), 32'(cmd));
      if (cmd) check_val("mem_wdata", mem_write_data, model_wdata(f3, addr, wd));
      check_val("req_ready_busy", 32'(req_ready), 32'd0);
      if (delay >= 0) begin
        repeat (delay) begin @(posedge clk); #1; end
        check_val("no_early_resp", 32'(resp_valid), 32'd0);
        mem_valid = 1'b1; mem_load_data = ldata;
        @(posedge clk); #1;
        mem_valid = 1'b0; mem_load_data = $urandom;
        check_val("resp_after_valid", 32'(resp_valid), 32'd1);
      end else begin
        n = 0;
        while (!resp_valid && n < 200) begin @(posedge clk); #1; n++; end
        check_val("timeout_cycles", 32'(n), 32'(TO));
        e = 2'd2;
      end
      check_val("enable_dropped", 32'(mem_enable), 32'd0);
    end
    exp_rdata = (e == 2'd0 && cmd == 1'b0) ? model_rdata(f3, addr, ldata) : 32'd0;
    check_val("resp_err", 32'(resp_err), 32'(e));
    check_val("resp_rdata", resp_rdata, exp_rdata);
    check_val("resp_rd", 32'(resp_rd), 32'(rd));
    for (int i = 0; i < hold; i++) begin
      mem_valid = 1'($urandom_range(1));
      @(posedge clk); #1;
      mem_valid = 1'b0;
      check_val("hold_valid", 32'(resp_valid), 32'd1);
      check_val("hold_err", 32'(resp_err), 32'(e));
      check_val("hold_rdata", resp_rdata, exp_rdata);
      check_val("hold_req_ready", 32'(req_ready), 32'd0);
      check_val("hold_no_enable", 32'(mem_enable), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check_val("resp_consumed", 32'(resp_valid), 32'd0);
    check_val("req_ready_after", 32'(req_ready), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    logic        cmd;
    logic [2:0]  f3;
    logic [31:0] addr;
    int          dly;
    reset_n = 1'b0; req_valid = 1'b0; req_cmd = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; req_rd = '0; resp_ready = 1'b0;
    mem_valid = 1'b0; mem_load_data = '0;
    #12;
    check_val("rst_req_ready", 32'(req_ready), 32'd0);
    check_val("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_val("rst_mem_enable", 32'(mem_enable), 32'd0);
    check_val("rst_mem_addr", mem_addr, 32'd0);
    check_val("rst_resp_err", 32'(resp_err), 32'd0);
    @(negedge clk); reset_n = 1'b1;
    #1 check_val("post_rst_ready", 32'(req_ready), 32'd1);

    // mem_valid while idle must not produce anything
    @(negedge clk); mem_valid = 1'b1;
    @(posedge clk); #1; mem_valid = 1'b0;
    check_val("idle_mem_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);

    run_txn(1'b1, 3'd2, 32'h14, 32'h0000FFFF, 5'd1, 2, 32'h0, 0);
    run_txn(1'b1, 3'd0, 32'h17, 32'h000000AB, 5'd2, 1, 32'h0, 0);
    run_txn(1'b0, 3'd0, 32'h16, 32'h0, 5'd3, 0, 32'h00F00000, 0);
    run_txn(1'b0, 3'd5, 32'h16, 32'h0, 5'd4, 3, 32'h00F00000, 0);
    run_txn(1'b0, 3'd2, 32'h12, 32'h0, 5'd5, 0, 32'h0, 1);
    run_txn(1'b0, 3'd3, 32'h20, 32'h0, 5'd6, 0, 32'h0, 1);
    run_txn(1'b1, 3'd3, 32'h21, 32'h0, 5'd7, 0, 32'h0, 0);
    run_txn(1'b0, 3'd2, 32'h40, 32'h0, 5'd8, -1, 32'h0, 0);
    run_txn(1'b0, 3'd2, 32'h44, 32'h0, 5'd9, 63, 32'hCAFEF00D, 0);
    run_txn(1'b0, 3'd1, 32'h2, 32'h0, 5'd10, 1, 32'h8001_1234, 5);

    for (int t = 0; t < 40; t++) begin
      cmd = 1'($urandom_range(1));
      if ($urandom_range(3) != 0) begin
        if (cmd) f3 = 3'($urandom_range(2));
        else begin
          f3 = 3'($urandom_range(4));
          if (f3 == 3'd3) f3 = 3'd5;
        end
      end else f3 = 3'($urandom_range(7));
      addr = $urandom;
      case ($urandom_range(2))
        0: addr = addr & 32'hFFFFFFFC;
        1: addr = addr & 32'hFFFFFFFE;
        default: ;
      endcase
      dly = ($urandom_range(11) == 0) ? -1 : int'($urandom_range(4));
      run_txn(cmd, f3, addr, $urandom, 5'($urandom), dly, $urandom,
              int'($urandom_range(3)));
    end

    // Reset in the middle of an access
    req_valid = 1'b1; req_cmd = 1'b0; req_funct3 = 3'd2; req_addr = 32'h100; req_rd = 5'd11;
    @(posedge clk); #1; req_valid = 1'b0;
    check_val("rst_mid_enable_on", 32'(mem_enable), 32'd1);
    repeat (2) begin @(posedge clk); #1; end
    #2 reset_n = 1'b0;
    #1;
    check_val("rst_mid_enable_off", 32'(mem_enable), 32'd0);
    check_val("rst_mid_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk); reset_n = 1'b1;
    #1 check_val("rst_mid_ready_back", 32'(req_ready), 32'd1);
    mem_valid = 1'b1; mem_load_data = 32'h12345678;
    @(posedge clk); #1; mem_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check_val("rst_mid_no_stale", 32'(resp_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
